// File: rtl/wb_arbiter.sv
// Writeback arbiter owning the register-file write port: merges in-order pipeline results with
// queued mul/div results, bounds mul/div starvation, squashes r0 writes. Optional WB_BYPASS_EN adds a forwarding path.
module wb_arbiter #(
    parameter int MD_DEPTH = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef WB_BYPASS_EN
    input  logic [4:0]                  byp_rsc,
    input  logic [4:0]                  byp_rtc,
    input  logic [31:0]                 rf_rs,
    input  logic [31:0]                 rf_rt,
    output logic [31:0]                 byp_rs,
    output logic [31:0]                 byp_rt,
`endif
    input  logic                        pipe_valid,
    output logic                        pipe_ready,
    input  logic                        pipe_we,
    input  logic [4:0]                  pipe_rdc,
    input  logic [31:0]                 pipe_data,
    input  logic                        md_valid,
    output logic                        md_ready,
    input  logic [4:0]                  md_rdc,
    input  logic [31:0]                 md_data,
    output logic                        reg_we,
    output logic [4:0]                  reg_rdc,
    output logic [31:0]                 reg_rd,
    output logic [$clog2(MD_DEPTH):0]   md_pending
);
    localparam int AW = $clog2(MD_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(MD_DEPTH);
    localparam logic [WW-1:0] MAX_W   = WW'(MAX_WAIT);

    typedef enum logic {GNT_PIPE, GNT_MD} grant_t;

    typedef struct packed {
        logic [4:0]  rdc;
        logic [31:0] data;
    } md_entry_t;

    md_entry_t     mem [MD_DEPTH];
    md_entry_t     head;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic [WW-1:0] wait_reg, wait_next;
    grant_t        grant_reg, grant_next;
    logic          fifo_empty, pipe_fire, push, pop;

    // Ready signals depend only on registered state, never on the valids.
    assign pipe_ready = (grant_reg != GNT_MD);
    assign md_ready   = (count_reg != DEPTH_C);
    assign md_pending = count_reg;
    assign head       = mem[rd_ptr_reg];

    always_comb begin
        fifo_empty = (count_reg == '0);
        pipe_fire  = pipe_valid && pipe_ready;
        push       = md_valid && md_ready;
        pop        = !pipe_fire && !fifo_empty;

        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (!push && pop)
            count_next = count_reg - CW'(1);

        wait_next = wait_reg;
        if (pop || fifo_empty)
            wait_next = '0;
        else if (wait_reg != MAX_W)
            wait_next = wait_reg + WW'(1);

        // Grant holds force_md for the coming cycle, precomputed from next occupancy/wait.
        grant_next = GNT_PIPE;
        if ((count_next != '0) && (wait_next >= MAX_W))
            grant_next = GNT_MD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_reg  <= GNT_PIPE;
            count_reg  <= '0;
            wait_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            reg_we     <= 1'b0;
            reg_rdc    <= '0;
            reg_rd     <= '0;
        end else begin
            grant_reg <= grant_next;
            count_reg <= count_next;
            wait_reg  <= wait_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);

            if (pipe_fire) begin
                reg_we  <= pipe_we && (pipe_rdc != 5'd0);
                reg_rdc <= pipe_rdc;
                reg_rd  <= pipe_data;
            end else if (!fifo_empty) begin
                reg_we  <= (head.rdc != 5'd0);
                reg_rdc <= head.rdc;
                reg_rd  <= head.data;
            end else begin
                reg_we  <= 1'b0;
            end
        end
    end

    // Storage has no reset so it can map onto distributed/block RAM; occupancy guards stale entries.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= '{rdc: md_rdc, data: md_data};
    end

`ifdef WB_BYPASS_EN
    assign byp_rs = (reg_we && (reg_rdc == byp_rsc) && (byp_rsc != 5'd0)) ? reg_rd : rf_rs;
    assign byp_rt = (reg_we && (reg_rdc == byp_rtc) && (byp_rtc != 5'd0)) ? reg_rd : rf_rt;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, pipe path, r0 squash, FIFO full/order, starvation, async reset.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid, pipe_we, md_valid;
    logic        pipe_ready, md_ready, reg_we;
    logic [4:0]  pipe_rdc, md_rdc, reg_rdc;
    logic [31:0] pipe_data, md_data, reg_rd;
    logic [1:0]  md_pending;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_rsc, byp_rtc;
    logic [31:0] rf_rs, rf_rt, byp_rs, byp_rt;
`endif

    int vectors = 0;
    int miscompares = 0;

    wb_arbiter #(.MD_DEPTH(2), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef WB_BYPASS_EN
        .byp_rsc(byp_rsc), .byp_rtc(byp_rtc), .rf_rs(rf_rs), .rf_rt(rf_rt),
        .byp_rs(byp_rs), .byp_rt(byp_rt),
`endif
        .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_we(pipe_we),
        .pipe_rdc(pipe_rdc), .pipe_data(pipe_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_rdc(md_rdc), .md_data(md_data),
        .reg_we(reg_we), .reg_rdc(reg_rdc), .reg_rd(reg_rd), .md_pending(md_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pipe_drive(input logic v, input logic [4:0] rdc, input logic [31:0] d);
        pipe_valid = v; pipe_we = 1'b1; pipe_rdc = rdc; pipe_data = d;
    endtask

    task automatic md_drive(input logic v, input logic [4:0] rdc, input logic [31:0] d);
        md_valid = v; md_rdc = rdc; md_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        pipe_drive(1'b0, 5'd0, 32'h0);
        md_drive(1'b0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
        byp_rsc = 5'd0; byp_rtc = 5'd0; rf_rs = 32'h0; rf_rt = 32'h0;
`endif
        #1;
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_reg_rdc", 32'(reg_rdc), 32'd0);
        chk("rst_reg_rd", reg_rd, 32'd0);
        chk("rst_pending", 32'(md_pending), 32'd0);
        chk("rst_pipe_ready", 32'(pipe_ready), 32'd1);
        chk("rst_md_ready", 32'(md_ready), 32'd1);
        tick(); tick();
        rst_n = 1'b1;

        // Pipe write, 1-cycle latency, then outputs hold with we=0
        pipe_drive(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        pipe_valid = 1'b0;
        chk("pipe_we", 32'(reg_we), 32'd1);
        chk("pipe_rdc", 32'(reg_rdc), 32'd5);
        chk("pipe_rd", reg_rd, 32'hDEADBEEF);
        tick();
        chk("idle_we", 32'(reg_we), 32'd0);
        chk("idle_rdc_hold", 32'(reg_rdc), 32'd5);
        chk("idle_rd_hold", reg_rd, 32'hDEADBEEF);

        // r0 squash and pipe_we=0
        pipe_drive(1'b1, 5'd0, 32'h1234);
        tick();
        chk("r0_pipe_we", 32'(reg_we), 32'd0);
        chk("r0_pipe_rd", reg_rd, 32'h1234);
        pipe_drive(1'b1, 5'd7, 32'h77);
        pipe_we = 1'b0;
        tick();
        pipe_valid = 1'b0;
        chk("nowe_pipe_we", 32'(reg_we), 32'd0);
        chk("nowe_pipe_rdc", 32'(reg_rdc), 32'd7);

        md_drive(1'b1, 5'd0, 32'hAA);
        tick();
        md_valid = 1'b0;
        chk("r0_md_push_pending", 32'(md_pending), 32'd1);
        chk("r0_md_push_we", 32'(reg_we), 32'd0);
        tick();
        chk("r0_md_pop_we", 32'(reg_we), 32'd0);
        chk("r0_md_pop_rd", reg_rd, 32'hAA);
        chk("r0_md_pop_pending", 32'(md_pending), 32'd0);

        // Mul/div latency: push cycle, then pop cycle
        md_drive(1'b1, 5'd12, 32'hC0C0);
        tick();
        md_valid = 1'b0;
        chk("md_lat_push_we", 32'(reg_we), 32'd0);
        tick();
        chk("md_lat_pop_we", 32'(reg_we), 32'd1);
        chk("md_lat_pop_rdc", 32'(reg_rdc), 32'd12);
        chk("md_lat_pop_rd", reg_rd, 32'hC0C0);

        // Full FIFO behind continuous pipe traffic, forced pop, strict order
        pipe_drive(1'b1, 5'd21, 32'h2121);
        md_drive(1'b1, 5'd8, 32'h80);
        tick();
        chk("full_p1_pending", 32'(md_pending), 32'd1);
        chk("full_p1_pipe_rdc", 32'(reg_rdc), 32'd21);
        md_drive(1'b1, 5'd9, 32'h90);
        tick();
        chk("full_p2_pending", 32'(md_pending), 32'd2);
        chk("full_p2_md_ready", 32'(md_ready), 32'd0);
        md_drive(1'b1, 5'd10, 32'hA0);
        tick();
        chk("full_stall_pending", 32'(md_pending), 32'd2);
        chk("full_stall_pipe_ready", 32'(pipe_ready), 32'd1);
        tick(); tick();
        chk("full_force_pipe_ready", 32'(pipe_ready), 32'd0);
        chk("full_force_md_ready", 32'(md_ready), 32'd0);
        tick();
        chk("full_forced_rdc", 32'(reg_rdc), 32'd8);
        chk("full_forced_rd", reg_rd, 32'h80);
        chk("full_forced_we", 32'(reg_we), 32'd1);
        chk("full_no_push_on_pop", 32'(md_pending), 32'd1);
        chk("full_pipe_resumes", 32'(pipe_ready), 32'd1);
        tick();
        md_valid = 1'b0;
        pipe_valid = 1'b0;
        chk("full_p3_pending", 32'(md_pending), 32'd2);
        chk("full_p3_pipe_rdc", 32'(reg_rdc), 32'd21);
        tick();
        chk("drain1_rdc", 32'(reg_rdc), 32'd9);
        chk("drain1_rd", reg_rd, 32'h90);
        tick();
        chk("drain2_rdc", 32'(reg_rdc), 32'd10);
        chk("drain2_rd", reg_rd, 32'hA0);
        tick();
        chk("drain_done_we", 32'(reg_we), 32'd0);
        chk("drain_done_pending", 32'(md_pending), 32'd0);

        // Starvation bound: single entry, pipe continuously valid
        md_drive(1'b1, 5'd8, 32'h88);
        tick();
        md_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pipe_drive(1'b1, 5'(16 + i), 32'(i));
            tick();
            chk("starve_pipe_rdc", 32'(reg_rdc), 32'(16 + i));
        end
        pipe_drive(1'b1, 5'd20, 32'h20);
        chk("starve_pipe_ready", 32'(pipe_ready), 32'd0);
        tick();
        chk("starve_md_rdc", 32'(reg_rdc), 32'd8);
        chk("starve_md_rd", reg_rd, 32'h88);
        chk("starve_resume_ready", 32'(pipe_ready), 32'd1);
        tick();
        chk("starve_after_rdc", 32'(reg_rdc), 32'd20);

        // Async reset mid-traffic
        md_drive(1'b1, 5'd11, 32'hB0);
        tick();
        md_valid = 1'b0;
        chk("pre_rst_we", 32'(reg_we), 32'd1);
        chk("pre_rst_pending", 32'(md_pending), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", 32'(reg_we), 32'd0);
        chk("async_rst_pending", 32'(md_pending), 32'd0);
        chk("async_rst_pipe_ready", 32'(pipe_ready), 32'd1);
        chk("async_rst_md_ready", 32'(md_ready), 32'd1);
        pipe_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_we", 32'(reg_we), 32'd0);

`ifdef WB_BYPASS_EN
        pipe_drive(1'b1, 5'd3, 32'h55);
        tick();
        pipe_valid = 1'b0;
        byp_rsc = 5'd3; rf_rs = 32'h11; byp_rtc = 5'd4; rf_rt = 32'h22;
        #1;
        chk("byp_rs_hit", byp_rs, 32'h55);
        chk("byp_rt_miss", byp_rt, 32'h22);
        byp_rsc = 5'd0; byp_rtc = 5'd3;
        #1;
        chk("byp_rs_r0", byp_rs, 32'h11);
        chk("byp_rt_hit", byp_rt, 32'h55);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
